module_ctrl_mult: RTL

Sequencer for the keypad → Booth multiplier → BCD → 7-segment datapath. It watches operand-ready flags from the keypad and launches the multiplier with a one-cycle valid pulse. It sequences BCD conversions, selects which value the display shows, enforces watchdog timeouts, and clears the keypad after a result hold period or a user clear. It sits in the top level on clk_div, between module_teclado and the multiplier/display chain.

---
 rtl/module_ctrl_mult_if.sv | 42 ++++
 rtl/module_ctrl_mult.sv | 128 ++++++++++++
 2 files changed

// File: rtl/module_ctrl_mult_if.sv
// module_ctrl_mult_if
// Handshake bundle between the multiply sequencer and its surroundings
// (keypad, Booth multiplier, BCD converter, display mux).
//
// Signals:
//   listo_1, listo_2   keypad -> ctrl   level: operand 1 / operand 2 captured
//   mult_done          mult   -> ctrl   pulse: product valid
//   bcd_listo          bcd    -> ctrl   pulse: digits valid
//   clear_req          user   -> ctrl   pulse: clear / abort
//   mult_valid         ctrl   -> mult   pulse: start multiplication
//   bcd_start          ctrl   -> bcd    pulse: convert current display source
//   disp_sel[1:0]      ctrl   -> disp   0 blank, 1 num_1, 2 num_2, 3 product
//   teclado_clr        ctrl   -> keypad pulse: clear operands
//   busy, error        ctrl   -> top    status levels
//   state_dbg[2:0]     ctrl   -> top    current state encoding
//
// Modports: master = environment side, slave = the controller.

interface module_ctrl_mult_if;
  logic       listo_1;
  logic       listo_2;
  logic       mult_done;
  logic       bcd_listo;
  logic       clear_req;
  logic       mult_valid;
  logic       bcd_start;
  logic [1:0] disp_sel;
  logic       teclado_clr;
  logic       busy;
  logic       error;
  logic [2:0] state_dbg;

  modport master (
    output listo_1, listo_2, mult_done, bcd_listo, clear_req,
    input  mult_valid, bcd_start, disp_sel, teclado_clr, busy, error, state_dbg
  );

  modport slave (
    input  listo_1, listo_2, mult_done, bcd_listo, clear_req,
    output mult_valid, bcd_start, disp_sel, teclado_clr, busy, error, state_dbg
  );
endinterface

// File: rtl/module_ctrl_mult.sv
// module_ctrl_mult
// Moore sequencer for the keypad -> Booth multiplier -> BCD -> 7-segment
// chain. Launches the multiplier once both operands are captured, requests
// BCD conversions, picks the display source, guards the multiplier and the
// converter with a watchdog, and clears the keypad after the result hold
// time or on a user clear.
//
// Parameters:
//   TIMEOUT_CYC  cycles allowed in S_WAIT / S_CONV before S_ERR (>= 2)
//   HOLD_CYC     cycles the product is shown before auto-clear (0 = forever)
//   CNT_W        width of the shared timeout/hold counter
//
// Ports:
//   clk  system clock (clk_div domain), rising edge
//   rst  asynchronous reset, active low
//   bus  handshake bundle, slave side (see module_ctrl_mult_if)
//
// All outputs are registered from the next-state value, so they change on
// the same edge as the state and are glitch free.

module module_ctrl_mult #(
  parameter int TIMEOUT_CYC = 64,
  parameter int HOLD_CYC    = 1000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  module_ctrl_mult_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_OP1   = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_CONV  = 3'd4,
    S_SHOW  = 3'd5,
    S_ERR   = 3'd6,
    S_CLR   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             listo_1_q;
  logic             entering;

  function automatic logic [1:0] disp_of(state_t s);
    logic [1:0] d;
    d = 2'd0;
    case (s)
      S_OP1:           d = 2'd1;
      S_START, S_WAIT: d = 2'd2;
      S_CONV, S_SHOW:  d = 2'd3;
      default:         d = 2'd0;
    endcase
    return d;
  endfunction

  always_comb begin
    // NOTE: state_nxt gets a default before any branch so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_nxt = state;
    if (bus.clear_req && state != S_CLR) begin
      state_nxt = S_CLR;
    end else begin
      case (state)
        S_IDLE:  if (bus.listo_1 && !listo_1_q) state_nxt = S_OP1;
        S_OP1:   if (bus.listo_2) state_nxt = S_START;
        S_START: state_nxt = S_WAIT;
        S_WAIT: begin
          // A product arriving in the timeout cycle still counts.
          if (bus.mult_done)     state_nxt = S_CONV;
          else if (cnt == TO_LAST) state_nxt = S_ERR;
        end
        S_CONV: begin
          if (bus.bcd_listo)     state_nxt = S_SHOW;
          else if (cnt == TO_LAST) state_nxt = S_ERR;
        end
        S_SHOW:  if (HOLD_CYC > 0 && cnt == HOLD_LAST) state_nxt = S_CLR;
        S_ERR:   state_nxt = S_ERR;
        S_CLR:   state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // The counter restarts whenever the state changes, so it always reads the
  // number of cycles already spent in the current state.
  assign entering = (state_nxt != state);

  // NOTE: reset is asynchronous and clears every flop here, outputs included,
  // so a reset mid-operation silences the datapath before the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= S_IDLE;
      cnt             <= '0;
      listo_1_q       <= 1'b0;
      bus.mult_valid  <= 1'b0;
      bus.bcd_start   <= 1'b0;
      bus.disp_sel    <= 2'd0;
      bus.teclado_clr <= 1'b0;
      bus.busy        <= 1'b0;
      bus.error       <= 1'b0;
      bus.state_dbg   <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_nxt;
      listo_1_q <= bus.listo_1;
      if (entering)      cnt <= '0;
      else if (cnt != '1) cnt <= cnt + CNT_W'(1);

      bus.mult_valid  <= (state_nxt == S_START);
      bus.bcd_start   <= (state_nxt == S_START) ||
                         (entering && (state_nxt == S_OP1 || state_nxt == S_CONV));
      bus.disp_sel    <= disp_of(state_nxt);
      bus.teclado_clr <= (state_nxt == S_CLR);
      bus.busy        <= (state_nxt == S_START) || (state_nxt == S_WAIT) ||
                         (state_nxt == S_CONV);
      bus.error       <= (state_nxt == S_ERR);
      bus.state_dbg   <= state_nxt;
    end
  end

endmodule
